// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse receiver.
// Holds the byte-frame FSM encoding, frame geometry, the bit positions of the
// stream-mode status byte (byte0) and the overflow saturation values.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } byte_state_e;

    localparam int unsigned FRAME_DATA_BITS = 8;

    // Byte0 (status byte) field positions
    localparam int unsigned BTN_L    = 0;
    localparam int unsigned BTN_R    = 1;
    localparam int unsigned BTN_M    = 2;
    localparam int unsigned SYNC_BIT = 3;
    localparam int unsigned XS       = 4;
    localparam int unsigned YS       = 5;
    localparam int unsigned XO       = 6;
    localparam int unsigned YO       = 7;

    localparam logic [8:0] DIF_POS_SAT = 9'h0ff;  // +255
    localparam logic [8:0] DIF_NEG_SAT = 9'h100;  // -256

    // Build one 9-bit signed axis delta; an overflowing axis saturates
    // toward the direction given by its sign bit.
    function automatic logic [8:0] axis_dif(input logic sign, input logic ovf,
                                            input logic [7:0] mag);
        if (ovf) begin
            return sign ? DIF_NEG_SAT : DIF_POS_SAT;
        end
        return {sign, mag};
    endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 byte receiver: pin synchronisers, ps2_clk glitch filter, 11-bit frame
// FSM and an inactivity timeout.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   i_ps2_clk/dat  raw pad inputs (asynchronous)
//   i_pkt_busy     packet assembler is mid-packet (arms the timeout)
//   o_byte         received byte, valid while o_byte_valid is high
//   o_byte_valid   one-cycle pulse, the cycle after the stop-bit strobe
//   o_byte_err     one-cycle pulse on bad start, parity or stop bit
//   o_timeout      one-cycle pulse when the line stalls mid-frame/packet
module ps2_byte_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    input  logic       i_pkt_busy,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_byte_err,
    output logic       o_timeout
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic strobe_q, strobe_d;

    byte_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic valid_q, valid_d, err_q, err_d, timeout_q, timeout_d;
    logic armed;

    // Lines idle high, so synchronisers and filter reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
            strobe_q  <= 1'b0;
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            to_cnt_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            clk_s1_q  <= i_ps2_clk;
            clk_s2_q  <= clk_s1_q;
            dat_s1_q  <= i_ps2_dat;
            dat_s2_q  <= dat_s1_q;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            strobe_q  <= strobe_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            to_cnt_q  <= to_cnt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    // Filtered clock flips after FILTER_LEN consecutive samples that differ
    // from the current level; any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        strobe_d = filt_q & ~filt_d;
    end

    assign armed = (state_q != StIdle) || i_pkt_busy;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        if (strobe_q) begin
            // A strobe always beats a simultaneous timeout.
            to_cnt_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (dat_s2_q) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(FRAME_DATA_BITS - 1)) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    if (^{shift_q, dat_s2_q}) begin
                        state_d = StStop;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                StStop: begin
                    state_d = StIdle;
                    valid_d = dat_s2_q;
                    err_d   = ~dat_s2_q;
                end
                default: state_d = StIdle;
            endcase
        end else if (armed) begin
            if (to_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
                timeout_d = 1'b1;
                state_d   = StIdle;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    assign o_byte       = shift_q;
    assign o_byte_valid = valid_q;
    assign o_byte_err   = err_q;
    assign o_timeout    = timeout_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse front end: assembles 3-byte stream packets,
// saturates overflowing deltas and keeps a clamped on-screen position.
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   i_ps2_clk, i_ps2_dat       raw PS/2 pad inputs
//   o_mouse_valid              one-cycle pulse per decoded packet
//   o_mouse_dif_x/y            signed deltas (Y uses PS/2 up-positive)
//   o_rect_pos_x/y             clamped position (Y screen-down positive)
//   o_mouse_btn                {M,R,L} from last good packet
//   o_frame_err                one-cycle pulse on any receive error
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SCR_W       = 640,
    parameter int unsigned SCR_H       = 480,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_dat,
    output logic        o_mouse_valid,
    output logic [8:0]  o_mouse_dif_x,
    output logic [8:0]  o_mouse_dif_y,
    output logic [11:0] o_rect_pos_x,
    output logic [11:0] o_rect_pos_y,
    output logic [2:0]  o_mouse_btn,
    output logic        o_frame_err
);

    logic [7:0] rx_byte;
    logic rx_valid, rx_err, rx_timeout;

    logic [1:0] idx_q, idx_d;
    logic [7:0] b0_q, b0_d, b1_q, b1_d;
    logic valid_q, valid_d, err_q, err_d;
    logic [8:0] dif_x_q, dif_x_d, dif_y_q, dif_y_d;
    logic [2:0] btn_q, btn_d;
    logic [11:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [8:0] dif_x_new, dif_y_new;
    logic signed [13:0] x_sum, y_sum;

    ps2_byte_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_byte_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_dat   (i_ps2_dat),
        .i_pkt_busy  (idx_q != 2'd0),
        .o_byte      (rx_byte),
        .o_byte_valid(rx_valid),
        .o_byte_err  (rx_err),
        .o_timeout   (rx_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            dif_x_q <= '0;
            dif_y_q <= '0;
            btn_q   <= '0;
            pos_x_q <= 12'(SCR_W / 2);
            pos_y_q <= 12'(SCR_H / 2);
        end else begin
            idx_q   <= idx_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            dif_x_q <= dif_x_d;
            dif_y_q <= dif_y_d;
            btn_q   <= btn_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
        end
    end

    // The third byte is consumed straight from the receiver, so the
    // deltas and new position are formed in the byte_valid cycle.
    always_comb begin
        dif_x_new = axis_dif(b0_q[XS], b0_q[XO], b1_q);
        dif_y_new = axis_dif(b0_q[YS], b0_q[YO], rx_byte);
        x_sum = $signed({2'b00, pos_x_q}) + $signed({{5{dif_x_new[8]}}, dif_x_new});
        y_sum = $signed({2'b00, pos_y_q}) - $signed({{5{dif_y_new[8]}}, dif_y_new});
    end

    always_comb begin
        idx_d   = idx_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        valid_d = 1'b0;
        err_d   = rx_err | rx_timeout;
        dif_x_d = dif_x_q;
        dif_y_d = dif_y_q;
        btn_d   = btn_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (rx_err || rx_timeout) begin
            idx_d = 2'd0;
        end else if (rx_valid) begin
            unique case (idx_q)
                2'd0: begin
                    // A status byte without the always-one bit means we are
                    // out of step with the device; stay on byte0 to resync.
                    if (rx_byte[SYNC_BIT]) begin
                        b0_d  = rx_byte;
                        idx_d = 2'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                2'd1: begin
                    b1_d  = rx_byte;
                    idx_d = 2'd2;
                end
                2'd2: begin
                    idx_d   = 2'd0;
                    valid_d = 1'b1;
                    dif_x_d = dif_x_new;
                    dif_y_d = dif_y_new;
                    btn_d   = {b0_q[BTN_M], b0_q[BTN_R], b0_q[BTN_L]};
                    if (x_sum[13]) begin
                        pos_x_d = '0;
                    end else if (x_sum[12:0] > 13'(SCR_W - 1)) begin
                        pos_x_d = 12'(SCR_W - 1);
                    end else begin
                        pos_x_d = x_sum[11:0];
                    end
                    if (y_sum[13]) begin
                        pos_y_d = '0;
                    end else if (y_sum[12:0] > 13'(SCR_H - 1)) begin
                        pos_y_d = 12'(SCR_H - 1);
                    end else begin
                        pos_y_d = y_sum[11:0];
                    end
                end
                default: idx_d = 2'd0;
            endcase
        end
    end

    assign o_mouse_valid = valid_q;
    assign o_frame_err   = err_q;
    assign o_mouse_dif_x = dif_x_q;
    assign o_mouse_dif_y = dif_y_q;
    assign o_mouse_btn   = btn_q;
    assign o_rect_pos_x  = pos_x_q;
    assign o_rect_pos_y  = pos_y_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: bit-banged PS/2 frames, an integer-arithmetic
// packet model checked every cycle, plus literal expectations per scenario.
// The PS/2 clock and timeout are scaled down to keep the run short.
module tb_ps2_mouse_rx;

    localparam int SCR_W       = 640;
    localparam int SCR_H       = 480;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 1000;
    localparam int HALF        = 200;  // PS/2 half period (20 system clocks)

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic        mouse_valid;
    logic [8:0]  dif_x, dif_y;
    logic [11:0] pos_x, pos_y;
    logic [2:0]  btn;
    logic        frame_err;

    ps2_mouse_rx #(
        .SCR_W      (SCR_W),
        .SCR_H      (SCR_H),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_dat    (ps2_dat),
        .o_mouse_valid(mouse_valid),
        .o_mouse_dif_x(dif_x),
        .o_mouse_dif_y(dif_y),
        .o_rect_pos_x (pos_x),
        .o_rect_pos_y (pos_y),
        .o_mouse_btn  (btn),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int valid_seen = 0;
    int err_seen = 0;
    logic [23:0] exp_q[$];

    // Model state: what the outputs must currently show
    int m_x = SCR_W / 2;
    int m_y = SCR_H / 2;
    int m_dx = 0;
    int m_dy = 0;
    int m_btn = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int axis(input bit sign, input bit ovf, input int mag);
        if (ovf) return sign ? -256 : 255;
        return sign ? mag - 256 : mag;
    endfunction

    task automatic model_apply(input logic [23:0] pkt);
        logic [7:0] b0;
        b0 = pkt[23:16];
        m_dx = axis(b0[4], b0[6], int'(pkt[15:8]));
        m_dy = axis(b0[5], b0[7], int'(pkt[7:0]));
        m_x = clampi(m_x + m_dx, SCR_W - 1);
        m_y = clampi(m_y - m_dy, SCR_H - 1);
        m_btn = int'(b0[2:0]);
    endtask

    // Every-cycle compare against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            m_x = SCR_W / 2;
            m_y = SCR_H / 2;
            m_dx = 0;
            m_dy = 0;
            m_btn = 0;
            prev_valid = 1'b0;
            check("rst_valid", int'(mouse_valid), 0);
            check("rst_err", int'(frame_err), 0);
        end else begin
            if (mouse_valid) begin
                valid_seen++;
                check("valid_single_cycle", int'(prev_valid), 0);
                if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
                else model_apply(exp_q.pop_front());
            end
            if (frame_err) err_seen++;
            prev_valid = mouse_valid;
        end
        check("dif_x", int'($signed(dif_x)), m_dx);
        check("dif_y", int'($signed(dif_y)), m_dy);
        check("btn", int'(btn), m_btn);
        check("pos_x", int'(pos_x), m_x);
        check("pos_y", int'(pos_y), m_y);
    end

    // Device drives data while the clock is high; host samples on the fall.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            #(HALF);
            ps2_clk = 1'b0;
            #(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        #(2 * HALF);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back({b0, b1, b2});
        send_frame(b0, 1'b0, 11);
        send_frame(b1, 1'b0, 11);
        send_frame(b2, 1'b0, 11);
    endtask

    // Send a good packet and require exactly one new valid and no error.
    task automatic good_pkt(input string name, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        int v0, e0;
        v0 = valid_seen;
        e0 = err_seen;
        send_pkt(b0, b1, b2);
        for (int i = 0; i < 200 && valid_seen == v0; i++) @(negedge clk);
        check({name, "_valid_cnt"}, valid_seen - v0, 1);
        check({name, "_err_cnt"}, err_seen - e0, 0);
    endtask

    initial begin
        int v0, e0;
        #1 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_lit_pos_x", int'(pos_x), 320);
        check("rst_lit_pos_y", int'(pos_y), 240);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        good_pkt("p1", 8'h08, 8'h05, 8'h03);
        check("p1_lit_dx", int'($signed(dif_x)), 5);
        check("p1_lit_dy", int'($signed(dif_y)), 3);
        check("p1_lit_x", int'(pos_x), 325);
        check("p1_lit_y", int'(pos_y), 237);
        check("p1_lit_btn", int'(btn), 0);

        // 0x39 has Ysign set, so a zero byte2 means dy = -256 -> y clamps.
        good_pkt("p2", 8'h39, 8'hF6, 8'h00);
        check("p2_lit_dx", int'(dif_x), 'h1F6);
        check("p2_lit_btn", int'(btn), 1);
        check("p2_lit_x", int'(pos_x), 315);
        check("p2_lit_y", int'(pos_y), 479);

        // Walk to (5,2): (315,479) -> (59,224) -> (5,2)
        good_pkt("w1", 8'h18, 8'h00, 8'hFF);
        good_pkt("w2", 8'h18, 8'hCA, 8'hDE);
        check("w2_lit_x", int'(pos_x), 5);
        check("w2_lit_y", int'(pos_y), 2);
        good_pkt("clamp_lo", 8'h38, 8'hEC, 8'hEC);
        check("clamp_lo_x", int'(pos_x), 0);
        check("clamp_lo_y", int'(pos_y), 22);
        for (int i = 0; i < 4; i++) good_pkt("sat_hi", 8'h08, 8'hFF, 8'h00);
        check("clamp_hi_x", int'(pos_x), 639);

        // X overflow: sign 0 -> +255, sign 1 -> -256 regardless of byte1
        good_pkt("ovf_pos", 8'h48, 8'h12, 8'h00);
        check("ovf_pos_dx", int'($signed(dif_x)), 255);
        good_pkt("ovf_neg", 8'h58, 8'h12, 8'h00);
        check("ovf_neg_dx", int'($signed(dif_x)), -256);

        // Bad parity on byte1: parity error, then its stop bit (a 1) is
        // seen by the idle FSM as a bad start bit -> two error pulses.
        v0 = valid_seen;
        e0 = err_seen;
        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h05, 1'b1, 11);
        repeat (20) @(negedge clk);
        check("par_err_cnt", err_seen - e0, 2);
        check("par_no_valid", valid_seen - v0, 0);
        good_pkt("after_par", 8'h09, 8'h01, 8'h01);
        check("after_par_btn", int'(btn), 1);

        // Byte0 without the sync bit is dropped
        v0 = valid_seen;
        e0 = err_seen;
        send_frame(8'h00, 1'b0, 11);
        repeat (20) @(negedge clk);
        check("sync_err_cnt", err_seen - e0, 1);
        check("sync_no_valid", valid_seen - v0, 0);
        good_pkt("after_sync", 8'h0A, 8'h02, 8'h00);

        // Stall after byte0
        v0 = valid_seen;
        e0 = err_seen;
        send_frame(8'h08, 1'b0, 11);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        check("timeout_err_cnt", err_seen - e0, 1);
        check("timeout_no_valid", valid_seen - v0, 0);
        good_pkt("after_to", 8'h08, 8'h03, 8'h04);

        // Reset mid-frame
        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h05, 1'b0, 5);
        ps2_dat = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_x", int'(pos_x), 320);
        check("midrst_y", int'(pos_y), 240);
        check("midrst_dx", int'(dif_x), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        good_pkt("post_rst", 8'h08, 8'h05, 8'h03);
        check("post_rst_x", int'(pos_x), 325);
        check("post_rst_y", int'(pos_y), 237);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
